// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: bus widths, FSM state encoding and port ids shared by the SRAM port arbiter.
package sram_arb_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;
endpackage

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: one-hot grant between ports A and B, round-robin on ties.
// SRAM_ARB_FIXED_PRIO_EN makes A always win ties and ignores last_grant.
module sram_rr_arbiter
    import sram_arb_pkg::*;
(
    input  logic  a_valid,
    input  logic  b_valid,
    input  logic  enable,
    input  port_t last_grant,
    output logic  a_grant,
    output logic  b_grant
);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign a_grant = enable & a_valid;
    assign b_grant = enable & b_valid & ~a_valid;
`else
    assign a_grant = enable & a_valid & (~b_valid | (last_grant == PORT_B));
    assign b_grant = enable & b_valid & (~a_valid | (last_grant == PORT_A));
`endif
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-requester arbiter driving an async SRAM with SETUP/STROBE/HOLD timing.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority instead of round-robin.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rsp_valid,
    input  logic              b_valid,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic              chip_enable,
    output logic              write_enable,
    output logic              output_enable
);
    state_t     state, state_nxt;
    port_t      port_q, last_grant;
    logic       wr_q, accept, a_grant, b_grant;
    logic [3:0] cnt;

    sram_rr_arbiter u_arb (
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .enable     (state == IDLE),
        .last_grant (last_grant),
        .a_grant    (a_grant),
        .b_grant    (b_grant)
    );

    assign a_ready = a_grant;
    assign b_ready = b_grant;
    assign accept  = a_grant | b_grant;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign last_grant = PORT_B;
`else
    always_ff @(posedge clk or posedge reset)
        if (reset) last_grant <= PORT_B;
        else if (accept) last_grant <= b_grant ? PORT_B : PORT_A;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? SETUP : IDLE;
            SETUP:   state_nxt = STROBE;
            STROBE:  state_nxt = (cnt == 4'd1) ? HOLD : STROBE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_q      <= 1'b0;
            port_q    <= PORT_A;
            address   <= '0;
            data_out  <= '0;
            rsp_rdata <= '0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                wr_q    <= b_grant ? b_write : a_write;
                port_q  <= b_grant ? PORT_B : PORT_A;
                address <= b_grant ? b_addr : a_addr;
                if (b_grant ? b_write : a_write) data_out <= b_grant ? b_wdata : a_wdata;
            end
            if (state == SETUP) cnt <= 4'(WAIT_CYCLES);
            else if (state == STROBE) cnt <= cnt - 4'd1;
            // capture on the edge that closes the final strobe cycle
            if (state == STROBE && cnt == 4'd1 && !wr_q) rsp_rdata <= data_in;
        end

    assign chip_enable   = (state == IDLE);
    assign write_enable  = !(state == STROBE && wr_q);
    assign output_enable = !(state == STROBE && !wr_q);
    assign data_oe       = wr_q && (state != IDLE);
    assign a_rsp_valid   = (state == HOLD) && (port_q == PORT_A);
    assign b_rsp_valid   = (state == HOLD) && (port_q == PORT_B);
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: strobe width in clk cycles, legal range 1..15.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports a_valid / b_valid, input, 1: requester A or B has an access pending.
REQ-005 SHALL have ports a_write / b_write, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have ports a_addr / b_addr, input, 8: SRAM word address.
REQ-007 SHALL have ports a_wdata / b_wdata, input, 16: write data.
REQ-008 SHALL have ports a_ready / b_ready, output, 1: request accepted this cycle.
REQ-009 SHALL have ports a_rsp_valid / b_rsp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 16: read data, valid while either rsp_valid is high.
REQ-011 SHALL have port address, output, 8: SRAM address.
REQ-012 SHALL have ports data_out (output, 16), data_oe (output, 1) and data_in (input, 16): the split SRAM data bus; the parent builds the tristate.
REQ-013 SHALL have ports chip_enable, write_enable and output_enable, output, 1 each: SRAM controls, all active-low.

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
REQ-015 Acceptance: in IDLE, when at least one valid is high, SHALL assert exactly one ready combinationally, latch that port's write/addr/wdata/port-id at the edge, and go to SETUP.
REQ-016 Requesters SHALL hold valid and payload stable until ready; a valid dropped before ready is a legal withdrawal.
REQ-017 Arbitration: SHALL use a last_grant register; if both valid, grant the port not last granted; if one valid, grant it; update last_grant on every accept.
REQ-018 SETUP (1 cycle): address = latched addr; chip_enable = 0; for writes data_oe = 1 and data_out = latched wdata.
REQ-019 STROBE (WAIT_CYCLES cycles, 4-bit down-counter): write_enable = 0 for writes, output_enable = 0 for reads; chip_enable stays 0.
REQ-020 Read capture: rsp_rdata SHALL register data_in at the edge ending the last STROBE cycle.
REQ-021 HOLD (1 cycle): both strobes = 1; chip_enable, address and data_oe held; the granted port's rsp_valid = 1 for reads and writes. On writes rsp_rdata holds its previous value.
REQ-022 Latency: rsp_valid SHALL appear WAIT_CYCLES+2 cycles after the accept edge; the next accept SHALL occur no earlier than the IDLE cycle following HOLD (one access per WAIT_CYCLES+3 cycles).
REQ-023 In IDLE, all SRAM controls SHALL be 1, data_oe = 0, and address SHALL hold its last value.
REQ-024 write_enable and output_enable SHALL never be 0 simultaneously; a strobe SHALL never be 0 while chip_enable = 1.
REQ-025 Valids arriving outside IDLE SHALL be ignored until IDLE, with ready held 0.

Reset
REQ-026 On reset (asynchronous): state = IDLE; chip_enable, write_enable, output_enable = 1; data_oe = 0; ready and rsp_valid = 0; address, data_out and rsp_rdata = 0; counter = 0; last_grant = B, so A wins the first tie.
REQ-027 Reset mid-access SHALL abort immediately with no rsp_valid; the in-flight access is lost and the SRAM content at that address is undefined.

Configuration
REQ-028 With macro SRAM_ARB_FIXED_PRIO_EN defined, port A SHALL always win ties, and last_grant is not implemented.
REQ-029 Without SRAM_ARB_FIXED_PRIO_EN, round-robin per REQ-017 SHALL apply.

Structure
REQ-030 Package sram_arb_pkg SHALL hold ADDR_W=8, DATA_W=16, the FSM state encoding, and the port-id encoding (PORT_A=0, PORT_B=1).
REQ-031 Grant logic SHALL be the sub-module sram_rr_arbiter (inputs: two valids, enable, last_grant; outputs: two one-hot grants), containing the macro-selected behaviour.

Verification
REQ-032 A writes addr 0x10 data 0xBEEF with WAIT_CYCLES=1 -> a_ready at the accept cycle; write_enable low exactly 1 cycle with data_oe=1; a_rsp_valid 3 cycles after accept.
REQ-033 A reads 0x10 after REQ-032 -> output_enable low 1 cycle; a_rsp_valid with rsp_rdata = 0xBEEF.
REQ-034 A and B valid continuously, round-robin -> grants alternate A, B, A, B; with SRAM_ARB_FIXED_PRIO_EN -> A only, B starved while A is valid.
REQ-035 WAIT_CYCLES=4, B reads 0xFF -> strobe low 4 cycles, b_rsp_valid 6 cycles after accept; B valid asserted during STROBE -> b_ready stays 0 until IDLE.
REQ-036 reset pulsed during STROBE of a write -> all controls 1 and data_oe=0 within the reset pulse, no rsp_valid, next tie granted to A.
REQ-037 All scenarios -> assertion of REQ-024 holds on every cycle.
